// File: rtl/m_clk_div_if.sv
// Control/status bundle for the programmable clock divider.
// master: the block requesting the divided clock (drives en/ratio_sel).
// slave : the divider itself (drives the clock and its status).
interface m_clk_div_if #(
  parameter int W = 8
);
  logic         en;
  logic [W-1:0] ratio_sel;
  logic         clk_out;
  logic         period_tick;
  logic         busy;
  logic         ratio_ack;
  logic [W-1:0] active_ratio;

  modport master (
    output en,
    output ratio_sel,
    input  clk_out,
    input  period_tick,
    input  busy,
    input  ratio_ack,
    input  active_ratio
  );

  modport slave (
    input  en,
    input  ratio_sel,
    output clk_out,
    output period_tick,
    output busy,
    output ratio_ack,
    output active_ratio
  );
endinterface

// File: rtl/m_clk_div.sv
// Programmable integer clock divider. Produces a registered, glitch-free
// divided clock: ratio changes and start/stop are applied only at period
// boundaries, so the downstream clock inverter never sees a runt pulse.
// High phase is ceil(N/2) cycles, low phase floor(N/2) cycles.
module m_clk_div #(
  parameter int W         = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  m_clk_div_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] RATIO_MIN = W'(2);
  localparam logic [W-1:0] ONE_W     = W'(1);
  localparam logic [W:0]   ONE_W1    = (W+1)'(1);

  state_t       state_r;
  logic [W-1:0] cnt_r;
  logic         clk_out_r;
  logic         tick_r;
  logic         busy_r;
  logic         ack_r;
  logic [W-1:0] ratio_r;

  logic [W-1:0] nc_s;         // clamped requested ratio
  logic [W-1:0] last_s;       // count value of the last cycle in a period
  logic [W:0]   cnt_inc_s;    // cnt+1, one bit wider so it never wraps
  logic [W:0]   half_s;       // ceil(A/2); extra bit covers A = 2^W-1
  logic         high_next_s;  // clk_out level for the next mid-period cycle

  // Clamp the requested ratio and derive period-position helpers.
  always_comb begin
    nc_s        = bus.ratio_sel;
    last_s      = ratio_r - ONE_W;
    cnt_inc_s   = {1'b0, cnt_r} + ONE_W1;
    half_s      = ({1'b0, ratio_r} + ONE_W1) >> 1;
    high_next_s = 1'b0;
    if (bus.ratio_sel < RATIO_MIN) begin
      nc_s = RATIO_MIN;
    end else begin
      nc_s = bus.ratio_sel;
    end
    if (cnt_inc_s < half_s) begin
      high_next_s = 1'b1;
    end else begin
      high_next_s = 1'b0;
    end
  end

  // Divider FSM; every output is a flop so clk_out has no combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      ratio_r   <= W'(DEF_RATIO);
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (bus.en) begin
            // Start: first edge of a fresh period, new ratio always acked.
            state_r   <= RUN;
            clk_out_r <= 1'b1;
            tick_r    <= 1'b1;
            busy_r    <= 1'b1;
            ack_r     <= 1'b1;
            ratio_r   <= nc_s;
          end else begin
            state_r   <= IDLE;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_r != last_s) begin
            // Mid-period: en and ratio_sel are deliberately ignored.
            cnt_r     <= cnt_inc_s[W-1:0];
            clk_out_r <= high_next_s;
            tick_r    <= 1'b0;
            ack_r     <= 1'b0;
          end else if (bus.en) begin
            // Boundary, continue: reload ratio, ack only on a real change.
            cnt_r     <= '0;
            clk_out_r <= 1'b1;
            tick_r    <= 1'b1;
            ratio_r   <= nc_s;
            ack_r     <= (nc_s != ratio_r);
          end else begin
            // Boundary, stop: low phase already complete, ratio kept.
            state_r   <= IDLE;
            cnt_r     <= '0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          clk_out_r <= 1'b0;
          tick_r    <= 1'b0;
          busy_r    <= 1'b0;
          ack_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out      = clk_out_r;
  assign bus.period_tick  = tick_r;
  assign bus.busy         = busy_r;
  assign bus.ratio_ack    = ack_r;
  assign bus.active_ratio = ratio_r;

endmodule

// File: tb/tb_m_clk_div.sv
// Directed bench for m_clk_div: a table of per-edge vectors followed by
// hand-written sequences for async reset mid-high-phase and maximum ratio.
module tb_m_clk_div;

  localparam int W = 8;

  typedef struct packed {
    logic         en;
    logic [W-1:0] rsel;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic         ack;
    logic [W-1:0] ar;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];

  m_clk_div_if #(.W(W)) bus ();

  m_clk_div #(.W(W), .DEF_RATIO(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic e, input int rs, input logic c,
                              input logic t, input logic b, input logic a,
                              input int ar);
    vec_t v;
    v.en      = e;
    v.rsel    = rs[W-1:0];
    v.clk_out = c;
    v.tick    = t;
    v.busy    = b;
    v.ack     = a;
    v.ar      = ar[W-1:0];
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input string name, input logic c, input logic t,
                            input logic b, input logic a, input logic [W-1:0] ar);
    n_vec++;
    if (bus.clk_out !== c || bus.period_tick !== t || bus.busy !== b ||
        bus.ratio_ack !== a || bus.active_ratio !== ar) begin
      n_err++;
      $display("FAIL %s: got clk_out=%b tick=%b busy=%b ack=%b ar=%0d, want clk_out=%b tick=%b busy=%b ack=%b ar=%0d",
               name, bus.clk_out, bus.period_tick, bus.busy, bus.ratio_ack,
               bus.active_ratio, c, t, b, a, ar);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Apply inputs, take one rising edge, settle just past it.
  task automatic step(input logic e, input logic [W-1:0] rs);
    bus.en        = e;
    bus.ratio_sel = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int highs;
    int ticks;
    int acks;
    int busy_lo;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.ratio_sel = 8'd4;

    // ---- vector table: en, ratio_sel -> clk_out, tick, busy, ack, active_ratio
    add(0, 4, 0, 0, 0, 0, 2);          // idle after reset, en low
    add(1, 4, 1, 1, 1, 1, 4);          // start at 4
    add(1, 4, 1, 0, 1, 0, 4);
    add(1, 4, 0, 0, 1, 0, 4);
    add(1, 4, 0, 0, 1, 0, 4);
    add(1, 4, 1, 1, 1, 0, 4);          // boundary, same ratio, no ack
    add(1, 6, 1, 0, 1, 0, 4);          // change to 6 on 2nd cycle: ignored
    add(1, 6, 0, 0, 1, 0, 4);
    add(1, 6, 0, 0, 1, 0, 4);
    add(1, 6, 1, 1, 1, 1, 6);          // boundary loads 6 with ack
    add(1, 6, 1, 0, 1, 0, 6);
    add(1, 6, 1, 0, 1, 0, 6);
    add(1, 6, 0, 0, 1, 0, 6);
    add(1, 6, 0, 0, 1, 0, 6);
    add(1, 6, 0, 0, 1, 0, 6);
    add(1, 6, 1, 1, 1, 0, 6);
    add(0, 6, 1, 0, 1, 0, 6);          // drop en at cnt=1: period completes
    add(0, 6, 1, 0, 1, 0, 6);
    add(0, 6, 0, 0, 1, 0, 6);
    add(0, 6, 0, 0, 1, 0, 6);
    add(0, 6, 0, 0, 1, 0, 6);
    add(0, 6, 0, 0, 0, 0, 6);          // boundary stop, busy falls
    add(0, 5, 0, 0, 0, 0, 6);          // idle ignores ratio_sel
    add(1, 5, 1, 1, 1, 1, 5);          // restart at 5
    add(1, 5, 1, 0, 1, 0, 5);
    add(1, 5, 1, 0, 1, 0, 5);
    add(1, 5, 0, 0, 1, 0, 5);
    add(1, 5, 0, 0, 1, 0, 5);
    add(1, 5, 1, 1, 1, 0, 5);
    add(1, 5, 1, 0, 1, 0, 5);
    add(1, 5, 1, 0, 1, 0, 5);
    add(1, 5, 0, 0, 1, 0, 5);
    add(1, 5, 0, 0, 1, 0, 5);
    add(1, 0, 1, 1, 1, 1, 2);          // 0 clamps to 2
    add(1, 0, 0, 0, 1, 0, 2);
    add(1, 1, 1, 1, 1, 0, 2);          // 1 clamps to 2, no ack
    add(1, 1, 0, 0, 1, 0, 2);
    add(1, 1, 1, 1, 1, 0, 2);
    add(1, 1, 0, 0, 1, 0, 2);
    add(0, 7, 0, 0, 0, 0, 2);          // stop wins over ratio change
    add(1, 8, 1, 1, 1, 1, 8);          // immediate restart after stop
    add(1, 8, 1, 0, 1, 0, 8);
    add(1, 8, 1, 0, 1, 0, 8);

    // Reset state while held
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].rsel);
      check_outs($sformatf("vec%0d", i), vecs[i].clk_out, vecs[i].tick,
                 vecs[i].busy, vecs[i].ack, vecs[i].ar);
    end

    // ---- async reset while clk_out is high at ratio 8
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b1, 8'd8);
    step(1'b1, 8'd8);
    check_outs("reset_ignores_en", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd8);
      check_outs($sformatf("restart8_%0d", i), (i < 4), (i == 0), 1'b1,
                 (i == 0), 8'd8);
    end

    // ---- maximum ratio 255: 128 high, 127 low, single tick and ack
    highs = 0;
    ticks = 0;
    acks = 0;
    busy_lo = 0;
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 8'd255);
      highs += int'(bus.clk_out);
      ticks += int'(bus.period_tick);
      acks += int'(bus.ratio_ack);
      busy_lo += int'(!bus.busy);
    end
    check_int("max_high_cycles", highs, 128);
    check_int("max_ticks", ticks, 1);
    check_int("max_acks", acks, 1);
    check_int("max_busy_low", busy_lo, 0);
    step(1'b1, 8'd255);
    check_outs("max_next_boundary", 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
